// File: rtl/dnn_wr_req_scheduler_if.sv
// Request bus between the PU write controllers, the write scheduler and the write path.
// The master modport is the scheduler side; slave is the PU/write-path side.
interface dnn_wr_req_scheduler_if #(
  parameter int unsigned NUM_PU         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned TX_SIZE_WIDTH  = 10,
  parameter int unsigned NUM_PU_W       = $clog2(NUM_PU) + 1
);
  logic [NUM_PU-1:0]                pu_wr_req;
  logic [NUM_PU*AXI_ADDR_WIDTH-1:0] pu_wr_addr;
  logic [NUM_PU*TX_SIZE_WIDTH-1:0]  pu_wr_size;
  logic [NUM_PU-1:0]                pu_wr_ack;
  logic [NUM_PU-1:0]                pu_wr_done;
  logic                             wr_req;
  logic [NUM_PU_W-1:0]              wr_pu_id;
  logic [AXI_ADDR_WIDTH-1:0]        wr_addr;
  logic [TX_SIZE_WIDTH-1:0]         wr_req_size;
  logic                             wr_ready;
  logic                             wr_done;

  modport master (
    input  pu_wr_req, pu_wr_addr, pu_wr_size, wr_ready, wr_done,
    output pu_wr_ack, pu_wr_done, wr_req, wr_pu_id, wr_addr, wr_req_size
  );

  modport slave (
    output pu_wr_req, pu_wr_addr, pu_wr_size, wr_ready, wr_done,
    input  pu_wr_ack, pu_wr_done, wr_req, wr_pu_id, wr_addr, wr_req_size
  );
endinterface

// File: rtl/dnn_wr_req_scheduler.sv
// Round-robin arbiter sharing the single DNN-to-AMI write path among NUM_PU units.
// One macro request is in flight at a time; completion is returned as a per-PU pulse.
module dnn_wr_req_scheduler #(
  parameter int unsigned NUM_PU         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned TX_SIZE_WIDTH  = 10,
  parameter int unsigned NUM_PU_W       = $clog2(NUM_PU) + 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dnn_wr_req_scheduler_if.master      bus,
  output logic                        busy,
  output logic [CNT_W-1:0]            done_count,
  output logic                        protocol_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [NUM_PU_W-1:0]       last_q, last_d;
  logic [NUM_PU-1:0]         owner_q, owner_d;
  logic [NUM_PU-1:0]         ack_q, ack_d;
  logic [NUM_PU-1:0]         pdone_q, pdone_d;
  logic                      wr_req_q, wr_req_d;
  logic [NUM_PU_W-1:0]       id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TX_SIZE_WIDTH-1:0]  size_q, size_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic [NUM_PU-1:0]         eligible, upper, cand, grant_oh;
  logic                      grant_vld;
  logic [NUM_PU_W-1:0]       grant_idx;
  logic [AXI_ADDR_WIDTH-1:0] grant_addr;
  logic [TX_SIZE_WIDTH-1:0]  grant_size;

  // A PU whose ack is on the bus this cycle has not yet had a chance to drop its request.
  always_comb begin
    eligible = bus.pu_wr_req & ~ack_q;
    upper    = '0;
    for (int i = 0; i < int'(NUM_PU); i++) begin
      upper[i] = (NUM_PU_W'(i) > last_q);
    end
    // Requesters above the last grant win; otherwise wrap to the lowest requester.
    cand       = ((eligible & upper) != '0) ? (eligible & upper) : eligible;
    grant_vld  = |cand;
    grant_idx  = '0;
    grant_oh   = '0;
    grant_addr = '0;
    grant_size = '0;
    for (int i = int'(NUM_PU) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_idx   = NUM_PU_W'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_addr  = bus.pu_wr_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        grant_size  = bus.pu_wr_size[i*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    ack_d    = '0;
    pdone_d  = '0;
    wr_req_d = 1'b0;
    id_d     = id_q;
    addr_d   = addr_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (bus.wr_done) begin
          err_d = 1'b1;
        end
        if (bus.wr_ready && grant_vld) begin
          last_d  = grant_idx;
          owner_d = grant_oh;
          ack_d   = grant_oh;
          id_d    = grant_idx;
          addr_d  = grant_addr;
          size_d  = grant_size;
          // Zero-size requests complete immediately without touching the write path.
          if (grant_size != '0) begin
            wr_req_d = 1'b1;
            state_d  = StWait;
          end else begin
            pdone_d = grant_oh;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      StWait: begin
        if (bus.wr_done) begin
          pdone_d = owner_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= NUM_PU_W'(NUM_PU - 1);
      owner_q  <= '0;
      ack_q    <= '0;
      pdone_q  <= '0;
      wr_req_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      pdone_q  <= pdone_d;
      wr_req_q <= wr_req_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.pu_wr_ack   = ack_q;
  assign bus.pu_wr_done  = pdone_q;
  assign bus.wr_req      = wr_req_q;
  assign bus.wr_pu_id    = id_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_req_size = size_q;
  assign busy            = (state_q == StWait);
  assign done_count      = cnt_q;
  assign protocol_err    = err_q;

endmodule

// File: tb/tb_dnn_wr_req_scheduler.sv
// Bench for dnn_wr_req_scheduler: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_dnn_wr_req_scheduler;
  localparam int unsigned NUM_PU = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned SW     = 10;
  localparam int unsigned NW     = 2;
  localparam int unsigned CW     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dnn_wr_req_scheduler_if #(
    .NUM_PU(NUM_PU), .AXI_ADDR_WIDTH(AW), .TX_SIZE_WIDTH(SW), .NUM_PU_W(NW)
  ) bus ();

  logic          busy;
  logic [CW-1:0] done_count;
  logic          protocol_err;

  dnn_wr_req_scheduler #(
    .NUM_PU(NUM_PU), .AXI_ADDR_WIDTH(AW), .TX_SIZE_WIDTH(SW), .NUM_PU_W(NW), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .done_count   (done_count),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  req;
    logic        rdy;
    logic        done;
    logic [9:0]  sz0;
    logic [9:0]  sz1;
    logic [1:0]  ack;
    logic [1:0]  pdone;
    logic        wrq;
    logic [1:0]  id;
    logic [31:0] addr;
    logic [9:0]  size;
    logic        bsy;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [1:0] req, logic rdy, logic done, logic [9:0] sz0,
                              logic [9:0] sz1, logic [1:0] ack, logic [1:0] pdone,
                              logic wrq, logic [1:0] id, logic [31:0] addr, logic [9:0] size,
                              logic bsy, logic [31:0] cnt, logic err);
    vec_t v;
    v.req = req; v.rdy = rdy; v.done = done; v.sz0 = sz0; v.sz1 = sz1;
    v.ack = ack; v.pdone = pdone; v.wrq = wrq; v.id = id; v.addr = addr;
    v.size = size; v.bsy = bsy; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic rdy, input logic done,
                       input logic [9:0] sz0, input logic [9:0] sz1);
    bus.pu_wr_req  = req;
    bus.wr_ready   = rdy;
    bus.wr_done    = done;
    bus.pu_wr_size = {sz1, sz0};
  endtask

  task automatic wait_wr_req(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.wr_req !== 1'b1 && n < 30);
    check({name, ".wr_req_seen"}, {63'd0, bus.wr_req}, 64'd1);
  endtask

  // Reference: one macro request in flight, round-robin pick among eligible PUs.
  task automatic run_random(input int ncyc);
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    int          m_last = int'(NUM_PU) - 1;
    logic [31:0] m_cnt = '0;
    bit          m_err = 1'b0;
    logic [1:0]  m_ack = '0;
    logic [1:0]  m_id = '0;
    logic [31:0] m_addr = '0;
    logic [9:0]  m_size = '0;
    logic [1:0]  req, e_ack, e_done;
    logic        e_wrq;
    logic [31:0] a[2];
    logic [9:0]  s[2];
    bit          rdy, dn, found;
    int          p;
    for (int c = 0; c < ncyc; c++) begin
      req = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        a[i] = $urandom;
        s[i] = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      dn = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      bus.pu_wr_addr = {a[1], a[0]};
      drive(req, rdy, dn, s[0], s[1]);
      e_ack = '0; e_done = '0; e_wrq = 1'b0;
      if (!m_busy) begin
        if (dn) m_err = 1'b1;
        found = 1'b0;
        if (rdy) begin
          for (int k = 1; k <= int'(NUM_PU); k++) begin
            p = (m_last + k) % int'(NUM_PU);
            if (!found && ((req >> p) & 2'b01) != 0 && ((m_ack >> p) & 2'b01) == 0) begin
              found  = 1'b1;
              m_last = p;
            end
          end
        end
        if (found) begin
          e_ack  = 2'b01 << m_last;
          m_id   = 2'(m_last);
          m_addr = a[m_last];
          m_size = s[m_last];
          if (m_size == 0) begin
            e_done = 2'b01 << m_last;
            m_cnt++;
          end else begin
            e_wrq   = 1'b1;
            m_busy  = 1'b1;
            m_owner = m_last;
          end
        end
      end else if (dn) begin
        e_done = 2'b01 << m_owner;
        m_cnt++;
        m_busy = 1'b0;
      end
      m_ack = e_ack;
      step();
      check("rnd.ack",   64'(bus.pu_wr_ack),   64'(e_ack));
      check("rnd.pdone", 64'(bus.pu_wr_done),  64'(e_done));
      check("rnd.wrq",   64'(bus.wr_req),      64'(e_wrq));
      check("rnd.id",    64'(bus.wr_pu_id),    64'(m_id));
      check("rnd.addr",  64'(bus.wr_addr),     64'(m_addr));
      check("rnd.size",  64'(bus.wr_req_size), 64'(m_size));
      check("rnd.busy",  64'(busy),            64'(m_busy));
      check("rnd.cnt",   64'(done_count),      64'(m_cnt));
      check("rnd.err",   64'(protocol_err),    64'(m_err));
    end
    drive(2'b00, 1'b1, 1'b0, 10'd0, 10'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(2'b01, 1'b1, 1'b0, 10'd4, 10'd0, 2'b01, 2'b00, 1'b1, 2'd0, 32'h1000, 10'd4, 1'b1, 32'd0, 1'b0);
    vecs[1]  = mk(2'b00, 1'b1, 1'b0, 10'd4, 10'd0, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b1, 32'd0, 1'b0);
    vecs[2]  = mk(2'b00, 1'b1, 1'b0, 10'd4, 10'd0, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b1, 32'd0, 1'b0);
    vecs[3]  = mk(2'b00, 1'b1, 1'b1, 10'd4, 10'd0, 2'b00, 2'b01, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd1, 1'b0);
    vecs[4]  = mk(2'b10, 1'b0, 1'b0, 10'd4, 10'd8, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd1, 1'b0);
    vecs[5]  = mk(2'b10, 1'b0, 1'b0, 10'd4, 10'd8, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd1, 1'b0);
    vecs[6]  = mk(2'b10, 1'b1, 1'b0, 10'd4, 10'd8, 2'b10, 2'b00, 1'b1, 2'd1, 32'h2000, 10'd8, 1'b1, 32'd1, 1'b0);
    vecs[7]  = mk(2'b00, 1'b1, 1'b1, 10'd4, 10'd8, 2'b00, 2'b10, 1'b0, 2'd1, 32'h2000, 10'd8, 1'b0, 32'd2, 1'b0);
    vecs[8]  = mk(2'b10, 1'b1, 1'b0, 10'd4, 10'd0, 2'b10, 2'b10, 1'b0, 2'd1, 32'h2000, 10'd0, 1'b0, 32'd3, 1'b0);
    vecs[9]  = mk(2'b10, 1'b1, 1'b0, 10'd4, 10'd0, 2'b00, 2'b00, 1'b0, 2'd1, 32'h2000, 10'd0, 1'b0, 32'd3, 1'b0);
    vecs[10] = mk(2'b01, 1'b1, 1'b0, 10'd4, 10'd0, 2'b01, 2'b00, 1'b1, 2'd0, 32'h1000, 10'd4, 1'b1, 32'd3, 1'b0);
    vecs[11] = mk(2'b00, 1'b1, 1'b1, 10'd4, 10'd0, 2'b00, 2'b01, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd4, 1'b0);
    vecs[12] = mk(2'b00, 1'b1, 1'b1, 10'd4, 10'd0, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd4, 1'b1);
    vecs[13] = mk(2'b00, 1'b1, 1'b0, 10'd4, 10'd0, 2'b00, 2'b00, 1'b0, 2'd0, 32'h1000, 10'd4, 1'b0, 32'd4, 1'b1);
    vecs[14] = mk(2'b10, 1'b1, 1'b0, 10'd4, 10'd6, 2'b10, 2'b00, 1'b1, 2'd1, 32'h2000, 10'd6, 1'b1, 32'd4, 1'b1);
    vecs[15] = mk(2'b00, 1'b1, 1'b1, 10'd4, 10'd6, 2'b00, 2'b10, 1'b0, 2'd1, 32'h2000, 10'd6, 1'b0, 32'd5, 1'b1);

    bus.pu_wr_addr = {32'h0000_2000, 32'h0000_1000};
    drive(2'b00, 1'b0, 1'b0, 10'd0, 10'd0);
    #12;
    check("rst.ack",   64'(bus.pu_wr_ack),   64'd0);
    check("rst.pdone", 64'(bus.pu_wr_done),  64'd0);
    check("rst.wrq",   64'(bus.wr_req),      64'd0);
    check("rst.addr",  64'(bus.wr_addr),     64'd0);
    check("rst.busy",  64'(busy),            64'd0);
    check("rst.cnt",   64'(done_count),      64'd0);
    check("rst.err",   64'(protocol_err),    64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].rdy, vecs[i].done, vecs[i].sz0, vecs[i].sz1);
      step();
      check($sformatf("v%0d.ack", i),   64'(bus.pu_wr_ack),   64'(vecs[i].ack));
      check($sformatf("v%0d.pdone", i), 64'(bus.pu_wr_done),  64'(vecs[i].pdone));
      check($sformatf("v%0d.wrq", i),   64'(bus.wr_req),      64'(vecs[i].wrq));
      check($sformatf("v%0d.id", i),    64'(bus.wr_pu_id),    64'(vecs[i].id));
      check($sformatf("v%0d.addr", i),  64'(bus.wr_addr),     64'(vecs[i].addr));
      check($sformatf("v%0d.size", i),  64'(bus.wr_req_size), 64'(vecs[i].size));
      check($sformatf("v%0d.busy", i),  64'(busy),            64'(vecs[i].bsy));
      check($sformatf("v%0d.cnt", i),   64'(done_count),      64'(vecs[i].cnt));
      check($sformatf("v%0d.err", i),   64'(protocol_err),    64'(vecs[i].err));
    end

    // Fairness: both PUs request continuously; grants must alternate starting at PU0.
    drive(2'b11, 1'b1, 1'b0, 10'd4, 10'd4);
    for (int n = 0; n < 4; n++) begin
      wait_wr_req($sformatf("fair%0d", n));
      check($sformatf("fair%0d.id", n), 64'(bus.wr_pu_id), 64'(n % 2));
      repeat (4) step();
      bus.wr_done = 1'b1;
      step();
      bus.wr_done = 1'b0;
      check($sformatf("fair%0d.pdone", n), 64'(bus.pu_wr_done), 64'(2'b01 << (n % 2)));
      check($sformatf("fair%0d.cnt", n), 64'(done_count), 64'(6 + n));
    end
    drive(2'b00, 1'b1, 1'b0, 10'd4, 10'd4);
    step();

    // Reset in the middle of an outstanding request.
    drive(2'b01, 1'b1, 1'b0, 10'd4, 10'd4);
    wait_wr_req("mid");
    check("mid.id", 64'(bus.wr_pu_id), 64'd0);
    drive(2'b00, 1'b1, 1'b0, 10'd4, 10'd4);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", 64'(busy),            64'd0);
    check("arst.cnt",  64'(done_count),      64'd0);
    check("arst.err",  64'(protocol_err),    64'd0);
    check("arst.addr", 64'(bus.wr_addr),     64'd0);
    check("arst.size", 64'(bus.wr_req_size), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 10'd4, 10'd4);
    step();
    check("post.ack",   64'(bus.pu_wr_ack),  64'd1);
    check("post.id",    64'(bus.wr_pu_id),   64'd0);
    check("post.wrq",   64'(bus.wr_req),     64'd1);
    drive(2'b00, 1'b1, 1'b0, 10'd4, 10'd4);
    step();
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    check("post.pdone", 64'(bus.pu_wr_done), 64'd1);
    check("post.cnt",   64'(done_count),     64'd1);
    check("post.err0",  64'(protocol_err),   64'd0);
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    check("post.err1",  64'(protocol_err),   64'd1);

    // Randomized traffic against the reference model from a fresh reset.
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 10'd0, 10'd0);
    step();
    rst_n = 1'b1;
    run_random(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
